cache_opr_seq: RTL and testbench
================================

# cache_opr_seq

Parametrised sequencer that starts on `valid` and enables a chain of NUM_OPR cache operations one after another. Each stage advances on its own completion handshake, not on a fixed counter. It drives cumulative (thermometer) enables, one-cycle start pulses and a sequence-done pulse. It sits between the cache request front-end and the per-operation cache sub-blocks, and also provides a configurable delayed copy of `valid` for the datapath.

## Interface

Parameters:
- NUM_OPR, 8: number of sequenced operations, 1..32.
- MIN_DWELL, 8: minimum cycles a stage stays current before its done is accepted, 1..255.
- VALID_DLY, 2: delay of `valid_dly` in cycles, 1..8.
- TIMEOUT_CYCLES, 64: stage timeout, must be greater than MIN_DWELL. Used only when CACHE_OPR_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  start request; sampled only in IDLE.
- abort  in  1  cancels a running sequence.
- opr_done  in  NUM_OPR  completion from stage i; only bit `cur` is looked at.
- valid_dly  out  1  `valid` delayed by VALID_DLY cycles.
- busy  out  1  high in RUN.
- opr_en  out  NUM_OPR  thermometer enables; bits 0..cur are high in RUN.
- opr_pulse  out  NUM_OPR  one-cycle pulse on the first cycle each opr_en bit is high.
- seq_done  out  1  one-cycle pulse after the last stage completes.
- err_timeout  out  NUM_OPR  sticky per-stage timeout flags.

## Operation

- States: IDLE and RUN. Registers: `cur` (stage index, $clog2(NUM_OPR) bits, minimum 1) and `dwell` (stage cycle counter, saturating, wide enough for TIMEOUT_CYCLES).
- IDLE, valid=1: go to RUN with cur=0 and dwell=0. err_timeout clears at this edge.
- RUN, per cycle:
  - dwell increments and saturates at its maximum.
  - Stage cur is accepted when dwell ≥ MIN_DWELL-1 and opr_done[cur]=1.
  - On accept with cur < NUM_OPR-1: cur increments, dwell resets to 0.
  - On accept with cur = NUM_OPR-1: go to IDLE and assert seq_done for the next cycle.
- opr_done is ignored while dwell < MIN_DWELL-1; an early done is not remembered.
- abort=1 in RUN: go to IDLE next edge with no seq_done. Abort wins over a simultaneous accept.
- abort in IDLE has no effect. valid together with abort in IDLE starts a sequence.
- valid in RUN is ignored; it is not queued.
- valid in the seq_done cycle (state is IDLE) starts a new sequence; seq_done and the new opr_pulse[0] are not overlapping.
- opr_en is cleared in IDLE. opr_pulse is registered, equal to opr_en & ~opr_en_prev.
- valid_dly is a VALID_DLY-deep shift register that runs in every state.

## Timing

- Reset values: state=IDLE, cur=0, dwell=0, busy=0, opr_en=0, opr_pulse=0, seq_done=0, err_timeout=0, valid_dly shift register all 0.
- valid high before edge E0: busy=1, opr_en[0]=1 and opr_pulse[0]=1 in the cycle after E0.
- Stage i is current for at least MIN_DWELL cycles. If done is held high, each stage lasts exactly MIN_DWELL cycles.
- Last accept at edge Ek: after Ek, opr_en=0, busy=0, seq_done=1 for one cycle.
- Minimum sequence length with opr_done tied high: NUM_OPR*MIN_DWELL cycles in RUN.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronous). No seq_done is produced.

## Configuration

- CACHE_OPR_TIMEOUT_EN defined:
  - When dwell reaches TIMEOUT_CYCLES-1 without an accept, the stage is force-accepted (same advance or finish as a normal accept) and err_timeout[cur] is set.
  - The error flag stays set until the next start.
  - A force-accept on the last stage still produces seq_done.
- CACHE_OPR_TIMEOUT_EN undefined: a stage waits indefinitely, err_timeout is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan

- NUM_OPR=8, MIN_DWELL=8, opr_done=all 1s, 1-cycle valid:
  - opr_pulse[i] at cycles 1+8i.
  - opr_en fills 0x01→0xFF.
  - seq_done at cycle 65, busy low from cycle 65.
- opr_done[2] delayed to dwell=20, all other done bits high: stage 2 lasts 21 cycles, seq_done at cycle 78. opr_done[3] pulsed at dwell=3 is ignored.
- abort at cycle 30 together with opr_done[cur]=1: opr_en=0 at cycle 31, seq_done never asserts. valid at cycle 32 restarts with opr_pulse[0] at cycle 33.
- valid held high continuously: a second sequence starts in the seq_done cycle, opr_pulse[0] the cycle after. valid_dly equals valid delayed by exactly 2 cycles.
- rst asserted at cycle 40 mid-stage 4: all outputs 0 asynchronously. After release, the block waits for a new valid.
- With CACHE_OPR_TIMEOUT_EN, TIMEOUT_CYCLES=64, opr_done[5]=0: stage 5 is force-advanced at dwell=63, err_timeout=0x20, seq_done still asserts. The flag clears on the next start.

Source files
------------

// File: rtl/cache_opr_seq.sv
// cache_opr_seq: starts on valid, then enables NUM_OPR cache operations one after another; each stage advances on its own done.
// Latency: opr_en[0]/opr_pulse[0] one cycle after valid is sampled; seq_done one cycle after the last stage is accepted.
// Backpressure: a stage holds (opr_en steady) until opr_done[cur] after MIN_DWELL cycles; optional stage timeout under CACHE_OPR_TIMEOUT_EN.
module cache_opr_seq #(
    parameter int NUM_OPR        = 8,
    parameter int MIN_DWELL      = 8,
    parameter int VALID_DLY      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               abort,
    input  logic [NUM_OPR-1:0] opr_done,
    output logic               valid_dly,
    output logic               busy,
    output logic [NUM_OPR-1:0] opr_en,
    output logic [NUM_OPR-1:0] opr_pulse,
    output logic               seq_done,
    output logic [NUM_OPR-1:0] err_timeout
);

    localparam int CW   = (NUM_OPR > 1) ? $clog2(NUM_OPR) : 1;
    // The dwell counter must reach the timeout threshold as well as the minimum dwell.
    localparam int DMAX = (TIMEOUT_CYCLES > MIN_DWELL) ? TIMEOUT_CYCLES : MIN_DWELL;
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [CW-1:0] LAST_STAGE = CW'(NUM_OPR - 1);
    localparam logic [DW-1:0] DWELL_MIN  = DW'(MIN_DWELL - 1);
    localparam logic [DW-1:0] DWELL_SAT  = {DW{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cur_q, cur_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [NUM_OPR-1:0]   opr_en_q, opr_en_d;
    logic [NUM_OPR-1:0]   opr_pulse_q, opr_pulse_d;
    logic                 seq_done_q, seq_done_d;
    logic [VALID_DLY-1:0] vdly_q;

    logic run;
    logic done_cur;
    logic accept;
    logic timeout_hit;
    logic advance;

    assign run      = (state_q == S_RUN);
    assign done_cur = opr_done[cur_q];
    // Done is only looked at once the stage has dwelt long enough; an earlier done is simply dropped.
    assign accept   = run && (dwell_q >= DWELL_MIN) && done_cur;
    assign advance  = accept || timeout_hit;

`ifdef CACHE_OPR_TIMEOUT_EN
    logic [NUM_OPR-1:0] err_q, err_d;

    assign timeout_hit = run && (dwell_q == DW'(TIMEOUT_CYCLES - 1));

    // Timeout flags: cleared on a new start, set for a stage that is force-accepted without its done.
    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && valid) begin
            err_d = '0;
        end else if (run && !abort && timeout_hit && !accept) begin
            err_d[cur_q] = 1'b1;
        end
    end

    // Timeout flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    // Without the timeout option a stage waits for its done indefinitely.
    assign timeout_hit = 1'b0;
    assign err_timeout = '0;
`endif

    // Next-state for the sequencer FSM, stage index, dwell counter and enables.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        dwell_d    = dwell_q;
        seq_done_d = 1'b0;
        opr_en_d   = '0;

        case (state_q)
            S_IDLE: begin
                // abort has no effect here; valid alone decides the start.
                if (valid) begin
                    state_d = S_RUN;
                    cur_d   = '0;
                    dwell_d = '0;
                end
            end
            S_RUN: begin
                dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + 1'b1;
                if (abort) begin
                    // Abort beats a simultaneous accept and never produces seq_done.
                    state_d = S_IDLE;
                    cur_d   = '0;
                    dwell_d = '0;
                end else if (advance) begin
                    if (cur_q == LAST_STAGE) begin
                        state_d    = S_IDLE;
                        cur_d      = '0;
                        dwell_d    = '0;
                        seq_done_d = 1'b1;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        dwell_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cur_d   = '0;
                dwell_d = '0;
            end
        endcase

        // Thermometer enables follow the next state so they line up with their start pulses.
        for (int i = 0; i < NUM_OPR; i++) begin
            opr_en_d[i] = (state_d == S_RUN) && (CW'(i) <= cur_d);
        end
        opr_pulse_d = opr_en_d & ~opr_en_q;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            dwell_q     <= '0;
            opr_en_q    <= '0;
            opr_pulse_q <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            dwell_q     <= dwell_d;
            opr_en_q    <= opr_en_d;
            opr_pulse_q <= opr_pulse_d;
            seq_done_q  <= seq_done_d;
        end
    end

    // Delayed copy of valid for the datapath; runs regardless of sequencer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdly_q <= '0;
        end else begin
            vdly_q[0] <= valid;
            for (int i = 1; i < VALID_DLY; i++) begin
                vdly_q[i] <= vdly_q[i-1];
            end
        end
    end

    assign valid_dly = vdly_q[VALID_DLY-1];
    assign busy      = run;
    assign opr_en    = opr_en_q;
    assign opr_pulse = opr_pulse_q;
    assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_cache_opr_seq.sv
// Scoreboard bench for cache_opr_seq: stimulus pushes expected pulse/done events, a negedge monitor pops and compares.
// Cycle numbers are relative to the cycle in which valid is driven high (that cycle is 0).
// Expected cycles are hand-derived from MIN_DWELL=8, NUM_OPR=8, VALID_DLY=2, TIMEOUT_CYCLES=64.
module tb_cache_opr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] opr_done = '0;
    logic       valid_dly;
    logic       busy;
    logic [7:0] opr_en;
    logic [7:0] opr_pulse;
    logic       seq_done;
    logic [7:0] err_timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         c;
        logic [7:0] p;
        logic [7:0] en;
        logic       d;
        logic       b;
        logic [7:0] e;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_x;
    logic vh1 = 1'b0;
    logic vh2 = 1'b0;

    cache_opr_seq #(
        .NUM_OPR(8),
        .MIN_DWELL(8),
        .VALID_DLY(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid(valid),
        .abort(abort),
        .opr_done(opr_done),
        .valid_dly(valid_dly),
        .busy(busy),
        .opr_en(opr_en),
        .opr_pulse(opr_pulse),
        .seq_done(seq_done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: valid_dly against a two-deep history, and every pulse/done event against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            vh1 = 1'b0;
            vh2 = 1'b0;
        end else begin
            checks++;
            if (valid_dly !== vh2) begin
                failures++;
                $display("FAIL valid_dly cyc=%0d got=%b exp=%b", cyc, valid_dly, vh2);
            end
            vh2 = vh1;
            vh1 = valid;
            if ((opr_pulse != 8'h00) || seq_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d pulse=%h en=%h done=%b busy=%b err=%h",
                             cyc, opr_pulse, opr_en, seq_done, busy, err_timeout);
                end else begin
                    mon_x = exp_q.pop_front();
                    if ((cyc != mon_x.c) || (opr_pulse !== mon_x.p) || (opr_en !== mon_x.en) ||
                        (seq_done !== mon_x.d) || (busy !== mon_x.b) || (err_timeout !== mon_x.e)) begin
                        failures++;
                        $display("FAIL event got cyc=%0d pulse=%h en=%h done=%b busy=%b err=%h exp cyc=%0d pulse=%h en=%h done=%b busy=%b err=%h",
                                 cyc, opr_pulse, opr_en, seq_done, busy, err_timeout,
                                 mon_x.c, mon_x.p, mon_x.en, mon_x.d, mon_x.b, mon_x.e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_to(input int abs_c);
        while (cyc < abs_c) step();
    endtask

    task automatic push_ev(input int c, input logic [7:0] p, input logic [7:0] en,
                           input logic d, input logic b, input logic [7:0] e);
        ev_t x;
        x.c  = c;
        x.p  = p;
        x.en = en;
        x.d  = d;
        x.b  = b;
        x.e  = e;
        exp_q.push_back(x);
    endtask

    // Start pulse for stage i entered at absolute cycle c.
    task automatic push_stage(input int c, input int i, input logic [7:0] e);
        push_ev(c, 8'(1 << i), 8'((1 << (i + 1)) - 1), 1'b0, 1'b1, e);
    endtask

    // A full sequence with every done high: stage i starts at b+1+8i, seq_done at b+65.
    task automatic push_seq(input int b);
        for (int i = 0; i < 8; i++) push_stage(b + 1 + 8 * i, i, 8'h00);
        push_ev(b + 65, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic chk_q();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        int b;
        int b2;

        // Reset state.
        #1 rst = 1'b1;
        step(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_opr_en", 32'(opr_en), 32'd0);
        chk("rst_opr_pulse", 32'(opr_pulse), 32'd0);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_valid_dly", 32'(valid_dly), 32'd0);
        rst = 1'b0;
        step(2);

        // Nominal sequence, all done bits high, single-cycle valid.
        opr_done = 8'hFF;
        valid = 1'b1;
        b = cyc;
        push_seq(b);
        step();
        valid = 1'b0;
        go_to(b + 64);
        chk("a_busy_c64", 32'(busy), 32'd1);
        chk("a_en_c64", 32'(opr_en), 32'hFF);
        step();
        chk("a_busy_c65", 32'(busy), 32'd0);
        step();
        chk("a_done_one_cycle", 32'(seq_done), 32'd0);
        go_to(b + 75);
        chk_q();

        // Stage 2 done only at dwell 20; stage 3 done pulsed early at dwell 3, then held from dwell 7.
        do_reset();
        opr_done = 8'hF3;
        valid = 1'b1;
        b = cyc;
        for (int i = 0; i < 3; i++) push_stage(b + 1 + 8 * i, i, 8'h00);
        for (int i = 3; i < 8; i++) push_stage(b + 38 + 8 * (i - 3), i, 8'h00);
        push_ev(b + 78, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        step();
        valid = 1'b0;
        go_to(b + 36);
        chk("b_stage2_wait", 32'(opr_en), 32'h07);
        go_to(b + 37);
        opr_done[2] = 1'b1;
        step();
        opr_done[2] = 1'b0;
        go_to(b + 41);
        opr_done[3] = 1'b1;
        step();
        opr_done[3] = 1'b0;
        go_to(b + 44);
        chk("b_early_done_ignored", 32'(opr_en), 32'h0F);
        go_to(b + 45);
        opr_done[3] = 1'b1;
        go_to(b + 85);
        chk_q();

        // Abort in stage 3, restart with valid two cycles later.
        do_reset();
        opr_done = 8'hFF;
        valid = 1'b1;
        b = cyc;
        for (int i = 0; i < 4; i++) push_stage(b + 1 + 8 * i, i, 8'h00);
        step();
        valid = 1'b0;
        go_to(b + 30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("c_abort_en", 32'(opr_en), 32'd0);
        chk("c_abort_busy", 32'(busy), 32'd0);
        go_to(b + 32);
        valid = 1'b1;
        b2 = cyc;
        push_seq(b2);
        step();
        valid = 1'b0;
        go_to(b2 + 70);
        chk_q();

        // Abort coincident with the final accept: no seq_done.
        do_reset();
        valid = 1'b1;
        b = cyc;
        for (int i = 0; i < 8; i++) push_stage(b + 1 + 8 * i, i, 8'h00);
        step();
        valid = 1'b0;
        go_to(b + 64);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("c2_busy", 32'(busy), 32'd0);
        chk("c2_no_done", 32'(seq_done), 32'd0);
        step();
        chk("c2_no_done_late", 32'(seq_done), 32'd0);
        go_to(b + 75);
        chk_q();

        // valid together with abort in IDLE still starts.
        do_reset();
        valid = 1'b1;
        abort = 1'b1;
        b = cyc;
        push_seq(b);
        step();
        valid = 1'b0;
        abort = 1'b0;
        go_to(b + 70);
        chk_q();

        // valid held high: back-to-back sequences, restart in the seq_done cycle.
        do_reset();
        valid = 1'b1;
        b = cyc;
        push_seq(b);
        push_seq(b + 65);
        go_to(b + 100);
        valid = 1'b0;
        go_to(b + 140);
        chk("d_idle_after", 32'(busy), 32'd0);
        chk_q();

        // Asynchronous reset in the middle of stage 4.
        do_reset();
        valid = 1'b1;
        b = cyc;
        for (int i = 0; i < 5; i++) push_stage(b + 1 + 8 * i, i, 8'h00);
        step();
        valid = 1'b0;
        go_to(b + 40);
        chk("e_pre_rst_en", 32'(opr_en), 32'h1F);
        #2;
        rst = 1'b1;
        #1;
        chk("e_arst_busy", 32'(busy), 32'd0);
        chk("e_arst_en", 32'(opr_en), 32'd0);
        chk("e_arst_pulse", 32'(opr_pulse), 32'd0);
        chk("e_arst_done", 32'(seq_done), 32'd0);
        step(2);
        rst = 1'b0;
        step(20);
        chk("e_wait_valid", 32'(busy), 32'd0);
        chk_q();
        valid = 1'b1;
        b = cyc;
        push_seq(b);
        step();
        valid = 1'b0;
        go_to(b + 70);
        chk_q();

        // Stage 5 never completes.
        do_reset();
        opr_done = 8'hDF;
        valid = 1'b1;
        b = cyc;
        for (int i = 0; i < 6; i++) push_stage(b + 1 + 8 * i, i, 8'h00);
`ifdef CACHE_OPR_TIMEOUT_EN
        push_stage(b + 105, 6, 8'h20);
        push_stage(b + 113, 7, 8'h20);
        push_ev(b + 121, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20);
        step();
        valid = 1'b0;
        go_to(b + 104);
        chk("f_err_before", 32'(err_timeout), 32'd0);
        step();
        chk("f_err_set", 32'(err_timeout), 32'h20);
        go_to(b + 125);
        chk("f_err_sticky", 32'(err_timeout), 32'h20);
        opr_done = 8'hFF;
        valid = 1'b1;
        b2 = cyc;
        push_seq(b2);
        step();
        valid = 1'b0;
        chk("f_err_cleared", 32'(err_timeout), 32'd0);
        go_to(b2 + 70);
        chk_q();
`else
        step();
        valid = 1'b0;
        go_to(b + 200);
        chk("f_still_busy", 32'(busy), 32'd1);
        chk("f_hold_en", 32'(opr_en), 32'h3F);
        chk("f_no_err", 32'(err_timeout), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("f_abort_idle", 32'(busy), 32'd0);
        step(5);
        chk_q();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
